// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the direct-mapped data cache
package dcache_pkg;
  typedef enum logic {IDLE, REFILL} state_t;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [31:0] READ_POISON = 32'hDEADBEEF;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/data storage with async lookup and sync byte-lane write
// Ports: lk_idx_i/lk_tag_i lookup -> hit_o/line_o; we_* write port (fill_i also
// writes the tag and sets valid); rst clears all valid bits.
module dcache_array #(
  parameter int SETS = 256,
  localparam int IB = $clog2(SETS),
  localparam int TB = 32 - IB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IB-1:0] lk_idx_i,
  input  logic [TB-1:0] lk_tag_i,
  output logic          hit_o,
  output logic [31:0]   line_o,
  input  logic          we_i,
  input  logic          fill_i,
  input  logic [IB-1:0] we_idx_i,
  input  logic [TB-1:0] we_tag_i,
  input  logic [31:0]   we_data_i,
  input  logic [3:0]    we_lanes_i
);
  logic [SETS-1:0] valid_q;
  logic [TB-1:0]   tag_q  [SETS];
  logic [31:0]     data_q [SETS];
  always_comb begin
    hit_o  = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
    line_o = data_q[lk_idx_i];
  end
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else if (we_i && fill_i) valid_q[we_idx_i] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (we_i && fill_i) tag_q[we_idx_i] <= we_tag_i;
    for (int i = 0; i < 4; i++)
      if (we_i && we_lanes_i[i]) data_q[we_idx_i][8*i +: 8] <= we_data_i[8*i +: 8];
  end
endmodule

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped write-through no-write-allocate data cache
// Ports: cpu_* load/store request and load data, stall_o pipeline hold,
// mem_* data_mem interface. Defining DCACHE_STATS_EN adds hit_count_o and
// miss_count_o saturating load hit/miss counters.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int SETS = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_rd_en_i,
  input  logic        cpu_wr_en_i,
  input  logic [31:0] cpu_wr_data_i,
  input  logic [3:0]  cpu_byte_en_i,
  output logic [31:0] cpu_rd_data_o,
  output logic        stall_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_wr_data_o,
  output logic [3:0]  mem_byte_en_o,
  input  logic [31:0] mem_rd_data_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);
  localparam int IB = $clog2(SETS);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] miss_addr_q, miss_addr_d;
  logic hit, be_ok, refill, ld, miss, fill, upd;
  logic [31:0] line;
  always_comb begin
    be_ok  = (cpu_byte_en_i == BE_BYTE) || (cpu_byte_en_i == BE_HALF) || (cpu_byte_en_i == BE_WORD);
    refill = state_q == REFILL;
    // a simultaneous store wins; the load half of the request is dropped
    ld     = !rst && !refill && cpu_rd_en_i && !cpu_wr_en_i;
    miss   = ld && be_ok && !hit;
    fill   = !rst && refill && cnt_q == '0;
    upd    = !rst && !refill && cpu_wr_en_i && be_ok && hit;
    state_d     = miss ? REFILL : fill ? IDLE : state_q;
    cnt_d       = miss ? CW'(MEM_LATENCY - 1) : (refill && !fill) ? cnt_q - 1'b1 : '0;
    miss_addr_d = miss ? cpu_addr_i : miss_addr_q;
    stall_o       = !rst && (refill || miss);
    mem_addr_o    = rst ? 32'd0 : refill ? miss_addr_q : cpu_addr_i;
    mem_wr_en_o   = !rst && !refill && cpu_wr_en_i;
    mem_wr_data_o = cpu_wr_data_i;
    mem_byte_en_o = (rst || refill) ? BE_WORD : cpu_byte_en_i;
    cpu_rd_data_o = !ld ? 32'd0 :
                    !be_ok ? READ_POISON :
                    !hit ? 32'd0 :
                    cpu_byte_en_i == BE_BYTE ? {24'd0, line[7:0]} :
                    cpu_byte_en_i == BE_HALF ? {16'd0, line[15:0]} : line;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miss_addr_q <= miss_addr_d;
    end
  end
  always_ff @(posedge clk)
    if (!rst) assert (!(cpu_rd_en_i && cpu_wr_en_i));
  dcache_array #(.SETS(SETS)) u_array (
    .clk        (clk),
    .rst        (rst),
    .lk_idx_i   (cpu_addr_i[IB-1:0]),
    .lk_tag_i   (cpu_addr_i[31:IB]),
    .hit_o      (hit),
    .line_o     (line),
    .we_i       (fill || upd),
    .fill_i     (fill),
    .we_idx_i   (fill ? miss_addr_q[IB-1:0] : cpu_addr_i[IB-1:0]),
    .we_tag_i   (miss_addr_q[31:IB]),
    .we_data_i  (fill ? mem_rd_data_i : cpu_wr_data_i),
    .we_lanes_i (fill ? BE_WORD : cpu_byte_en_i)
  );
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  always_comb begin
    hit_cnt_d  = (ld && be_ok && hit && !(&hit_cnt_q)) ? hit_cnt_q + 32'd1 : hit_cnt_q;
    miss_cnt_d = (miss && !(&miss_cnt_q)) ? miss_cnt_q + 32'd1 : miss_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: directed stimulus with a queue-based scoreboard for dcache_dm
module tb_dcache_dm;
  localparam int K_LD = 0, K_ST = 1, K_RST = 2;
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          stalls;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cpu_addr_i = '0, cpu_wr_data_i = '0, cpu_rd_data_o;
  logic        cpu_rd_en_i = 1'b0, cpu_wr_en_i = 1'b0, stall_o, mem_wr_en_o;
  logic [3:0]  cpu_byte_en_i = 4'hF, mem_byte_en_o;
  logic [31:0] mem_addr_o, mem_wr_data_o, mem_rd_data_i;
  logic [31:0] mem [0:4095];
  exp_t q[$];
  int n_vec = 0, n_err = 0, stall_cnt = 0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_o, miss_count_o;
`endif
  always #5 clk = ~clk;
  dcache_dm #(.SETS(256), .MEM_LATENCY(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_rd_en_i   (cpu_rd_en_i),
    .cpu_wr_en_i   (cpu_wr_en_i),
    .cpu_wr_data_i (cpu_wr_data_i),
    .cpu_byte_en_i (cpu_byte_en_i),
    .cpu_rd_data_o (cpu_rd_data_o),
    .stall_o       (stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_en_o   (mem_wr_en_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_byte_en_o (mem_byte_en_o),
    .mem_rd_data_i (mem_rd_data_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count_o   (hit_count_o),
    .miss_count_o  (miss_count_o)
`endif
  );
  assign mem_rd_data_i = mem[mem_addr_o[11:0]];
  always @(posedge clk)
    if (mem_wr_en_o && (mem_byte_en_o == 4'b0001 || mem_byte_en_o == 4'b0011 || mem_byte_en_o == 4'b1111))
      for (int i = 0; i < 4; i++)
        if (mem_byte_en_o[i]) mem[mem_addr_o[11:0]][8*i +: 8] <= mem_wr_data_o[8*i +: 8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_cnt = 0;
      if (q.size() == 0) chk("rst_unexpected", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("rst_kind", 32'(e.kind), 32'(K_RST));
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en_o), 32'd0);
        chk("rst_be", 32'(mem_byte_en_o), 32'hF);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_rd_data", cpu_rd_data_o, 32'd0);
      end
    end else if (cpu_wr_en_i) begin
      if (q.size() == 0) chk("st_unexpected", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("st_kind", 32'(e.kind), 32'(K_ST));
        chk("st_wr_en", 32'(mem_wr_en_o), 32'd1);
        chk("st_addr", mem_addr_o, e.addr);
        chk("st_data", mem_wr_data_o, e.data);
        chk("st_be", 32'(mem_byte_en_o), 32'(e.be));
        chk("st_stall", 32'(stall_o), 32'd0);
      end
    end else if (cpu_rd_en_i) begin
      if (stall_o === 1'b1) begin
        stall_cnt++;
        chk("refill_addr", mem_addr_o, cpu_addr_i);
        chk("refill_wr_en", 32'(mem_wr_en_o), 32'd0);
      end else if (q.size() == 0) chk("ld_unexpected", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("ld_kind", 32'(e.kind), 32'(K_LD));
        chk("ld_data", cpu_rd_data_o, e.data);
        chk("ld_stalls", 32'(stall_cnt), 32'(e.stalls));
        stall_cnt = 0;
      end
    end
  end
  task automatic do_reset();
    q.push_back('{K_RST, 32'd0, 32'd0, 4'hF, 0});
    rst = 1'b1;
    cpu_rd_en_i = 1'b0;
    cpu_wr_en_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic load(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input int stalls);
    bit done = 0;
    q.push_back('{K_LD, a, d, be, stalls});
    cpu_addr_i = a;
    cpu_byte_en_i = be;
    cpu_rd_en_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall_o === 1'b0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL ld_timeout: addr %h still stalled after 20 cycles", a);
    end
    @(posedge clk);
    #1 cpu_rd_en_i = 1'b0;
  endtask
  task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    q.push_back('{K_ST, a, d, be, 0});
    cpu_addr_i = a;
    cpu_byte_en_i = be;
    cpu_wr_data_i = d;
    cpu_wr_en_i = 1'b1;
    @(posedge clk);
    #1 cpu_wr_en_i = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[12'h000] = 32'h12345678;
    mem[12'h100] = 32'h55667788;
    @(posedge clk);
    #1 do_reset();
    load(32'h00010000, 4'hF, 32'h12345678, 3);
    load(32'h00010000, 4'hF, 32'h12345678, 0);
    store(32'h00010000, 4'h1, 32'h000000AB);
    load(32'h00010000, 4'hF, 32'h123456AB, 0);
    load(32'h00010000, 4'h3, 32'h000056AB, 0);
    load(32'h00010000, 4'h1, 32'h000000AB, 0);
    store(32'h00010005, 4'hF, 32'hCAFEF00D);
    load(32'h00010005, 4'hF, 32'hCAFEF00D, 3);
    load(32'h00010100, 4'hF, 32'h55667788, 3);
    load(32'h00010000, 4'hF, 32'h123456AB, 3);
    load(32'h00010000, 4'h7, 32'hDEADBEEF, 0);
    store(32'h00010000, 4'h7, 32'hFFFFFFFF);
    load(32'h00010000, 4'hF, 32'h123456AB, 0);
    store(32'h00010005, 4'h3, 32'h00001234);
    load(32'h00010005, 4'hF, 32'hCAFE1234, 0);
    cpu_addr_i = 32'h00010200;
    cpu_byte_en_i = 4'hF;
    cpu_rd_en_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 do_reset();
    load(32'h00010005, 4'hF, 32'hCAFE1234, 3);
    load(32'h00010005, 4'hF, 32'hCAFE1234, 0);
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
